// File: rtl/rram_array_ctrl.sv
// RRAM crossbar sequencer: Wishbone register file plus an op FSM that drives
// the WL/BL/SL switch enables, supply selects, BL precharge and the column ADC.
//
// Handshakes: a Wishbone access is taken when cyc&stb hit the window while ack
// is low; ack is then high for exactly one cycle, and read data plus any write
// side effect belong to that cycle. The ADC is started by a one-cycle
// adc_start. The result is taken on any cycle of WAITADC in which adc_valid
// is high. adc_valid seen in any other state is ignored.
module rram_array_ctrl #(
    parameter int          ROWS        = 2,
    parameter int          COLS        = 2,
    parameter int          ADC_BITS    = 4,
    parameter logic [31:0] ADDR_BASE   = 32'h3000_0000,
    parameter int          SETTLE_CYC  = 8,
    parameter int          PRE_CYC     = 4,
    parameter int          SENSE_CYC   = 4,
    parameter int          ADC_TIMEOUT = 64,
    parameter logic [15:0] PULSE_DEF   = 16'd16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic [31:0]         wbs_dat_o,
    output logic                wbs_ack_o,
    output logic [ROWS-1:0]     wl_en,
    output logic [COLS-1:0]     bl_en,
    output logic [COLS-1:0]     sl_en,
    output logic [1:0]          wl_vsel,
    output logic [1:0]          bl_vsel,
    output logic                sl_vsel,
    output logic                pre_en,
    output logic [2:0]          adc_col,
    output logic                adc_start,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic                adc_valid,
    output logic                irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_PULSE, S_RELEASE, S_PRECH,
        S_SENSE, S_CONV, S_WAITADC, S_STORE, S_DONE
    } state_t;

    localparam logic [2:0]  OP_FORM     = 3'd1;
    localparam logic [2:0]  OP_SET      = 3'd2;
    localparam logic [2:0]  OP_RESET    = 3'd3;
    localparam logic [2:0]  OP_MAC      = 3'd5;
    localparam logic [5:0]  ROWS_L      = 6'(ROWS);
    localparam logic [3:0]  COLS_L      = 4'(COLS);
    localparam logic [2:0]  COL_LAST    = 3'(COLS - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] PRE_LAST    = 16'(PRE_CYC - 1);
    localparam logic [15:0] SENSE_LAST  = 16'(SENSE_CYC - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(ADC_TIMEOUT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [15:0]           r_cnt;
    logic                  r_ack;
    logic [31:0]           r_dat_o;
    logic [2:0]            r_op;
    logic [4:0]            r_row;
    logic [2:0]            r_col_sel;
    logic                  r_ie;
    logic                  r_done;
    logic                  r_timeout;
    logic                  r_busy_err;
    logic [15:0]           r_pulse;
    logic [4:0]            r_vsel;
    logic [ROWS-1:0]       r_rowmask;
    logic [2:0]            r_col;
    logic [ADC_BITS-1:0]   r_adc_q;
    logic [ADC_BITS-1:0]   r_result [COLS];
    logic [31:0]           w_rdata;

    // Bus decode and start qualification.
    logic       w_hit, w_acc, w_wr, w_busy, w_ctrl_wr, w_start;
    logic       w_range_ok, w_op_run, w_go, w_bad, w_berr, w_timeout_evt;
    logic [5:0] w_word;
    logic       w_unused;

    assign w_hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
    assign w_acc      = w_hit & ~r_ack;
    assign w_wr       = w_acc & wbs_we_i;
    assign w_word     = wbs_adr_i[7:2];
    assign w_busy     = (r_state != S_IDLE);
    assign w_ctrl_wr  = w_wr & (w_word == 6'h00);
    assign w_start    = w_ctrl_wr & wbs_dat_i[31];
    assign w_range_ok = ({1'b0, wbs_dat_i[12:8]} < ROWS_L) & ({1'b0, wbs_dat_i[18:16]} < COLS_L);
    assign w_op_run   = (wbs_dat_i[2:0] != 3'd0) & (wbs_dat_i[2:0] <= OP_MAC);
    assign w_go       = w_start & ~w_busy & w_range_ok & w_op_run;
    assign w_bad      = w_start & ~w_busy & ~w_range_ok;
    assign w_berr     = w_start & w_busy;
    assign w_timeout_evt = (r_state == S_WAITADC) & ~adc_valid & (r_cnt == WAIT_LAST);
    assign w_unused   = ^{wbs_adr_i[1:0], wbs_dat_i};

    // Cell selection patterns used by the drive states.
    logic [ROWS-1:0] w_row_oh, w_wl_read;
    logic [COLS-1:0] w_col_oh;
    logic [15:0]     w_pulse_last;
    logic            w_pulse_op;

    assign w_row_oh     = ROWS'(1) << r_row;
    assign w_col_oh     = COLS'(1) << r_col;
    assign w_wl_read    = (r_op == OP_MAC) ? r_rowmask : w_row_oh;
    assign w_pulse_last = (r_pulse == 16'd0) ? 16'd0 : r_pulse - 16'd1;
    assign w_pulse_op   = (r_op == OP_FORM) | (r_op == OP_SET) | (r_op == OP_RESET);

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat_o;
    assign irq       = r_done & r_ie;

    // Register read mux; unmapped offsets and absent result columns read 0.
    always_comb begin
        w_rdata = '0;
        case (w_word)
            6'h00:   w_rdata = {7'b0, r_ie, 5'b0, r_col_sel, 3'b0, r_row, 5'b0, r_op};
            6'h01:   w_rdata = {28'b0, r_busy_err, r_timeout, r_done, w_busy};
            6'h02:   w_rdata = {16'b0, r_pulse};
            6'h03:   w_rdata = {27'b0, r_vsel};
            6'h04:   w_rdata[ROWS-1:0] = r_rowmask;
            default: w_rdata = '0;
        endcase
        for (int c = 0; c < COLS; c++) begin
            if (w_word == 6'(8 + c)) w_rdata[ADC_BITS-1:0] = r_result[c];
        end
    end

    // FSM state register; the cycle counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || w_state_nxt == S_IDLE) ? 16'd0 : r_cnt + 16'd1;
        end
    end

    // Next state and analog drive; selects are held for the whole op so they
    // are stable before the first enable and after the last one drops.
    always_comb begin
        w_state_nxt = r_state;
        wl_en       = '0;
        bl_en       = '0;
        sl_en       = '0;
        pre_en      = 1'b0;
        adc_start   = 1'b0;
        adc_col     = 3'd0;
        wl_vsel     = 2'd0;
        bl_vsel     = 2'd0;
        sl_vsel     = 1'b0;
        if (r_state != S_IDLE) begin
            wl_vsel = r_vsel[1:0];
            bl_vsel = r_vsel[3:2];
            sl_vsel = r_vsel[4];
        end
        case (r_state)
            S_IDLE:    if (w_go) w_state_nxt = S_SETUP;
            S_SETUP:   if (r_cnt == SETTLE_LAST) w_state_nxt = w_pulse_op ? S_PULSE : S_PRECH;
            S_PULSE: begin
                wl_en = w_row_oh;
                bl_en = w_col_oh;
                sl_en = w_col_oh;
                if (r_cnt == w_pulse_last) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: w_state_nxt = S_DONE;
            S_PRECH: begin
                pre_en  = 1'b1;
                bl_en   = w_col_oh;
                adc_col = r_col;
                if (r_cnt == PRE_LAST) w_state_nxt = S_SENSE;
            end
            S_SENSE, S_CONV, S_WAITADC: begin
                wl_en   = w_wl_read;
                bl_en   = w_col_oh;
                sl_en   = w_col_oh;
                adc_col = r_col;
                if (r_state == S_SENSE && r_cnt == SENSE_LAST) w_state_nxt = S_CONV;
                if (r_state == S_CONV) begin
                    adc_start   = 1'b1;
                    w_state_nxt = S_WAITADC;
                end
                if (r_state == S_WAITADC) begin
                    if (adc_valid)          w_state_nxt = S_STORE;
                    else if (w_timeout_evt) w_state_nxt = S_RELEASE;
                end
            end
            S_STORE: begin
                adc_col     = r_col;
                w_state_nxt = (r_op == OP_MAC && r_col != COL_LAST) ? S_PRECH : S_RELEASE;
            end
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Bus response, config registers (frozen while busy), status flags and
    // the column walk / result capture of READ and MAC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_op       <= '0;
            r_row      <= '0;
            r_col_sel  <= '0;
            r_ie       <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_busy_err <= 1'b0;
            r_pulse    <= PULSE_DEF;
            r_vsel     <= '0;
            r_rowmask  <= '0;
            r_col      <= '0;
            r_adc_q    <= '0;
            for (int c = 0; c < COLS; c++) r_result[c] <= '0;
        end else begin
            r_ack   <= w_acc;
            r_dat_o <= w_acc ? w_rdata : 32'd0;
            if (w_ctrl_wr && !w_busy) begin
                r_op      <= wbs_dat_i[2:0];
                r_row     <= wbs_dat_i[12:8];
                r_col_sel <= wbs_dat_i[18:16];
                r_ie      <= wbs_dat_i[24];
            end
            if (w_wr && !w_busy && w_word == 6'h02) r_pulse   <= wbs_dat_i[15:0];
            if (w_wr && !w_busy && w_word == 6'h03) r_vsel    <= wbs_dat_i[4:0];
            if (w_wr && !w_busy && w_word == 6'h04) r_rowmask <= wbs_dat_i[ROWS-1:0];
            if (w_wr && w_word == 6'h01) begin
                if (wbs_dat_i[1]) r_done     <= 1'b0;
                if (wbs_dat_i[2]) r_timeout  <= 1'b0;
                if (wbs_dat_i[3]) r_busy_err <= 1'b0;
            end
            if (r_state == S_DONE || w_bad) r_done    <= 1'b1;
            if (w_timeout_evt || w_bad)     r_timeout <= 1'b1;
            if (w_berr)                     r_busy_err <= 1'b1;
            if (w_go) begin
                r_col <= (wbs_dat_i[2:0] == OP_MAC) ? 3'd0 : wbs_dat_i[18:16];
            end else if (r_state == S_STORE && w_state_nxt == S_PRECH) begin
                r_col <= r_col + 3'd1;
            end
            if (r_state == S_WAITADC && adc_valid) r_adc_q <= adc_data;
            if (r_state == S_STORE) begin
                for (int c = 0; c < COLS; c++) begin
                    if (r_col == 3'(c)) r_result[c] <= r_adc_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_rram_array_ctrl.sv
// Bench for rram_array_ctrl: register access over Wishbone, per-cycle drive
// trace against a phase-level model of each op, ADC responder, status checks.
`timescale 1ns/1ps
module tb_rram_array_ctrl;

    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int AB   = 4;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_PULSE  = 32'h3000_0008;
    localparam logic [31:0] A_VSEL   = 32'h3000_000C;
    localparam logic [31:0] A_RMASK  = 32'h3000_0010;
    localparam logic [31:0] A_RES0   = 32'h3000_0020;

    typedef struct {
        logic [15:0]   o;
        bit            v;
        logic [AB-1:0] d;
    } step_t;

    // Clock / reset and DUT signals
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            cyc, stb, we;
    logic [31:0]     adr, wdat;
    logic [31:0]     rdat;
    logic            ack;
    logic [ROWS-1:0] wl_en;
    logic [COLS-1:0] bl_en, sl_en;
    logic [1:0]      wl_vsel, bl_vsel;
    logic            sl_vsel, pre_en;
    logic [2:0]      adc_col;
    logic            adc_start;
    logic [AB-1:0]   adc_data;
    logic            adc_valid;
    logic            irq;

    rram_array_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .ADC_BITS(AB), .ADDR_BASE(32'h3000_0000),
        .SETTLE_CYC(8), .PRE_CYC(4), .SENSE_CYC(4), .ADC_TIMEOUT(64), .PULSE_DEF(16'd16)
    ) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_adr_i(adr),
        .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
        .wl_en(wl_en), .bl_en(bl_en), .sl_en(sl_en),
        .wl_vsel(wl_vsel), .bl_vsel(bl_vsel), .sl_vsel(sl_vsel),
        .pre_en(pre_en), .adc_col(adc_col), .adc_start(adc_start),
        .adc_data(adc_data), .adc_valid(adc_valid), .irq(irq)
    );

    // Scoreboard state and reference model registers
    int            n_vec = 0;
    int            n_err = 0;
    step_t         exp_q[$];
    logic [4:0]    m_vsel;
    logic [15:0]   m_pulse;
    logic [1:0]    m_rowmask;
    logic [AB-1:0] m_res [COLS];
    int            m_lat [COLS];
    logic [AB-1:0] m_dat [COLS];

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] obs();
        return {wl_en, bl_en, sl_en, wl_vsel, bl_vsel, sl_vsel, pre_en, adc_col, adc_start};
    endfunction

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    function automatic logic [31:0] ctrl_w(input int op, input int row, input int col,
                                           input bit ie, input bit start);
        return {start, 6'b0, ie, 5'b0, 3'(col), 3'b0, 5'(row), 5'b0, 3'(op)};
    endfunction

    // Driver tasks
    task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] q, output bit acked);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        acked = 1'b0;
        q = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                acked = 1'b1;
                q = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] q;
        bit          ak;
        wb_xfer(1'b1, a, d, q, ak);
        chk_vec("wr_ack", {31'b0, ak}, 32'd1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] q);
        bit ak;
        wb_xfer(1'b0, a, 32'd0, q, ak);
        chk_vec("rd_ack", {31'b0, ak}, 32'd1);
    endtask

    task automatic push(input int n, input logic [1:0] wl, input logic [1:0] bl,
                        input logic [1:0] sl, input logic pre, input logic [2:0] acol,
                        input logic st, input logic [4:0] vs, input bit v, input logic [AB-1:0] d);
        step_t s;
        s.o = {wl, bl, sl, vs[1:0], vs[3:2], vs[4], pre, acol, st};
        s.v = v;
        s.d = d;
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    // Phase-level model of one op: builds the expected cycle-by-cycle drive
    // starting with the first cycle after the start write is acknowledged.
    task automatic build_trace(input int op, input int row, input int col);
        int         p;
        int         first;
        int         last;
        bit         to;
        logic [1:0] wlp;
        exp_q.delete();
        push(2, 2'b0, 2'b0, 2'b0, 1'b0, 3'd0, 1'b0, m_vsel, 1'b0, '0);
        push(1, 2'b0, 2'b0, 2'b0, 1'b0, 3'd0, 1'b0, m_vsel, 1'b1, AB'($urandom));
        push(5, 2'b0, 2'b0, 2'b0, 1'b0, 3'd0, 1'b0, m_vsel, 1'b0, '0);
        if (op <= 3) begin
            p = (m_pulse == 16'd0) ? 1 : int'(m_pulse);
            push(p, oh(row), oh(col), oh(col), 1'b0, 3'd0, 1'b0, m_vsel, 1'b0, '0);
        end else begin
            first = (op == 5) ? 0 : col;
            last  = (op == 5) ? COLS - 1 : col;
            to    = 1'b0;
            for (int c = first; c <= last && !to; c++) begin
                wlp = (op == 5) ? m_rowmask : oh(row);
                push(4, 2'b0, oh(c), 2'b0, 1'b1, 3'(c), 1'b0, m_vsel, 1'b0, '0);
                push(4, wlp, oh(c), oh(c), 1'b0, 3'(c), 1'b0, m_vsel, 1'b0, '0);
                push(1, wlp, oh(c), oh(c), 1'b0, 3'(c), 1'b1, m_vsel, 1'b0, '0);
                if (m_lat[c] == 0) begin
                    push(64, wlp, oh(c), oh(c), 1'b0, 3'(c), 1'b0, m_vsel, 1'b0, '0);
                    to = 1'b1;
                end else begin
                    push(m_lat[c] - 1, wlp, oh(c), oh(c), 1'b0, 3'(c), 1'b0, m_vsel, 1'b0, '0);
                    push(1, wlp, oh(c), oh(c), 1'b0, 3'(c), 1'b0, m_vsel, 1'b1, m_dat[c]);
                    push(1, 2'b0, 2'b0, 2'b0, 1'b0, 3'(c), 1'b0, m_vsel, 1'b0, '0);
                    m_res[c] = m_dat[c];
                end
            end
        end
        push(2, 2'b0, 2'b0, 2'b0, 1'b0, 3'd0, 1'b0, m_vsel, 1'b0, '0);
        push(2, 2'b0, 2'b0, 2'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0, '0);
    endtask

    // Walks the expected trace, checking the drive each cycle and acting as
    // the ADC (adc_valid/adc_data come from the trace entries).
    task automatic play_trace();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_vec($sformatf("trace%0d", i), {16'b0, obs()}, {16'b0, exp_q[i].o});
            adc_valid = exp_q[i].v;
            adc_data  = exp_q[i].v ? exp_q[i].d : AB'($urandom);
        end
        adc_valid = 1'b0;
    endtask

    task automatic run_op(input int op, input int row, input int col, input bit ie, input bit to);
        logic [31:0] q;
        build_trace(op, row, col);
        wr(A_CTRL, ctrl_w(op, row, col, ie, 1'b1));
        play_trace();
        rd(A_STATUS, q);
        chk_vec("op_status", q, to ? 32'h6 : 32'h2);
        chk_vec("op_irq", {31'b0, irq}, {31'b0, ie});
        for (int c = 0; c < COLS; c++) begin
            rd(A_RES0 + 32'(4 * c), q);
            chk_vec($sformatf("res%0d", c), q, {28'b0, m_res[c]});
        end
        wr(A_STATUS, 32'hE);
        rd(A_STATUS, q);
        chk_vec("w1c_status", q, 32'h0);
        chk_vec("w1c_irq", {31'b0, irq}, 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [31:0] tmp;
        bit          ak;
        bit          got;
        int          op, row, col;

        // Reset with random inputs on the bus and ADC
        rst = 1'b0;
        adc_valid = 1'b0; adc_data = '0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        for (int i = 0; i < 2; i++) begin
            cyc = 1'($urandom); stb = 1'($urandom); we = 1'($urandom);
            adr = {24'h300000, 8'($urandom)}; wdat = $urandom;
            adc_valid = 1'($urandom); adc_data = AB'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        chk_vec("rst_drive", {16'b0, obs()}, 32'd0);
        chk_vec("rst_ack", {31'b0, ack}, 32'd0);
        chk_vec("rst_irq", {31'b0, irq}, 32'd0);
        chk_vec("rst_dat", rdat, 32'd0);
        rst = 1'b1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adc_valid = 1'b0;
        m_vsel = '0; m_pulse = 16'd16; m_rowmask = '0;
        for (int c = 0; c < COLS; c++) m_res[c] = '0;
        rd(A_PULSE, q);   chk_vec("rst_pulse", q, 32'd16);
        rd(A_STATUS, q);  chk_vec("rst_status", q, 32'd0);
        rd(A_CTRL, q);    chk_vec("rst_ctrl", q, 32'd0);
        rd(A_VSEL, q);    chk_vec("rst_vsel", q, 32'd0);
        rd(A_RMASK, q);   chk_vec("rst_rmask", q, 32'd0);
        rd(A_RES0, q);    chk_vec("rst_res0", q, 32'd0);

        // Directed SET with interrupt enabled
        m_vsel = 5'h05; m_pulse = 16'd3;
        wr(A_VSEL, 32'h5);
        wr(A_PULSE, 32'd3);
        run_op(2, 1, 0, 1'b1, 1'b0);

        // Directed READ, ADC answers 3 cycles after adc_start
        m_lat[1] = 3; m_dat[1] = 4'hA;
        run_op(4, 0, 1, 1'b0, 1'b0);

        // Directed MAC over both columns
        m_rowmask = 2'b11;
        wr(A_RMASK, 32'h3);
        m_lat[0] = $urandom_range(1, 4); m_dat[0] = 4'h3;
        m_lat[1] = $urandom_range(1, 4); m_dat[1] = 4'h7;
        run_op(5, 0, 0, 1'b1, 1'b0);

        // ADC timeout on READ: result must be left alone
        m_lat[0] = 0;
        run_op(4, 1, 0, 1'b1, 1'b1);

        // Randomised ops
        for (int it = 0; it < 10; it++) begin
            bit to;
            m_vsel    = 5'($urandom);
            m_pulse   = 16'($urandom_range(0, 5));
            m_rowmask = 2'($urandom);
            wr(A_VSEL, {27'b0, m_vsel});
            wr(A_PULSE, {16'b0, m_pulse});
            wr(A_RMASK, {30'b0, m_rowmask});
            op  = $urandom_range(1, 5);
            row = $urandom_range(0, ROWS - 1);
            col = $urandom_range(0, COLS - 1);
            to  = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                m_lat[c] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                m_dat[c] = AB'($urandom);
            end
            if (op == 4 && m_lat[col] == 0) to = 1'b1;
            if (op == 5 && (m_lat[0] == 0 || m_lat[1] == 0)) to = 1'b1;
            run_op(op, row, col, 1'($urandom), to);
        end

        // Start while busy is ignored and flagged
        m_pulse = 16'd40;
        wr(A_PULSE, 32'd40);
        wr(A_CTRL, ctrl_w(2, 1, 0, 1'b0, 1'b1));
        rd(A_STATUS, q);
        chk_vec("busy_bit", q, 32'h1);
        wr(A_CTRL, ctrl_w(4, 0, 1, 1'b1, 1'b1));
        rd(A_CTRL, q);
        chk_vec("busy_ctrl_kept", q, ctrl_w(2, 1, 0, 1'b0, 1'b0));
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            rd(A_STATUS, q);
            if (q[1]) got = 1'b1;
        end
        chk_vec("busy_done_seen", {31'b0, got}, 32'd1);
        chk_vec("busy_err_status", q, 32'hA);
        wr(A_STATUS, 32'hE);

        // Out-of-range row/col: immediate done+timeout, nothing driven
        wr(A_CTRL, ctrl_w(4, 0, 2, 1'b0, 1'b1));
        @(negedge clk);
        chk_vec("badcol_drive", {16'b0, obs()}, 32'd0);
        rd(A_STATUS, q);
        chk_vec("badcol_status", q, 32'h6);
        wr(A_STATUS, 32'hE);
        wr(A_CTRL, ctrl_w(2, 2, 0, 1'b1, 1'b1));
        rd(A_STATUS, q);
        chk_vec("badrow_status", q, 32'h6);
        chk_vec("badrow_irq", {31'b0, irq}, 32'd1);
        wr(A_STATUS, 32'hE);

        // Outside the window: no ack, no effect; unmapped offsets read 0
        wb_xfer(1'b0, 32'h3000_0100, 32'd0, tmp, ak);
        chk_vec("nowin_rd_ack", {31'b0, ak}, 32'd0);
        wb_xfer(1'b1, 32'h3000_0108, 32'd7, tmp, ak);
        chk_vec("nowin_wr_ack", {31'b0, ak}, 32'd0);
        rd(A_PULSE, q);
        chk_vec("nowin_pulse", q, {16'b0, m_pulse});
        wr(32'h3000_0014, 32'hFFFF_FFFF);
        rd(32'h3000_0014, q);
        chk_vec("unmapped_rd", q, 32'd0);
        rd(32'h3000_0028, q);
        chk_vec("res_absent", q, 32'd0);

        // Reset in the middle of a pulse drops every enable
        m_vsel = 5'h1B;
        wr(A_VSEL, {27'b0, m_vsel});
        wr(A_CTRL, ctrl_w(3, 1, 1, 1'b0, 1'b1));
        repeat (12) @(negedge clk);
        chk_vec("midop_pulse", {16'b0, obs()},
                {16'b0, 2'b10, 2'b10, 2'b10, m_vsel[1:0], m_vsel[3:2], m_vsel[4], 1'b0, 3'd0, 1'b0});
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_vec("midop_rst_drive", {16'b0, obs()}, 32'd0);
        rd(A_STATUS, q);
        chk_vec("midop_rst_status", q, 32'd0);
        rd(A_PULSE, q);
        chk_vec("midop_rst_pulse", q, 32'd16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rram_array_ctrl.md
Name: rram_array_ctrl

Overview:
Parametrised sequencer for an RRAM in-memory-compute crossbar of ROWS word lines by COLS bit/source-line pairs. It is a Wishbone slave: software programs the op, the target cell or row mask, and the pulse timing, then starts the op. The block drives the digital enables and voltage-select codes for the WL/BL/SL analog switches and the precharge switch. It handshakes with the column ADC and buffers one result per column. It replaces fixed 2x2 single-cell control with FORM/SET/RESET/READ plus multi-row MAC over all columns.

Parameters:
ROWS, 2, number of word lines (1..32)
COLS, 2, number of BL/SL column pairs (1..8)
ADC_BITS, 4, ADC result width (1..16)
ADDR_BASE, 32'h3000_0000, Wishbone window base; decode on adr[31:8]
SETTLE_CYC, 8, cycles with voltage selects stable before any enable
PRE_CYC, 4, BL precharge cycles for READ/MAC
SENSE_CYC, 4, WL-on sense cycles before ADC start
ADC_TIMEOUT, 64, max cycles waiting for adc_valid
PULSE_DEF, 16, reset value of PULSE register

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_adr_i  in  32  Wishbone address
wbs_dat_i  in  32  Wishbone write data
wbs_dat_o  out  32  Wishbone read data
wbs_ack_o  out  1  Wishbone acknowledge
wl_en  out  ROWS  word-line switch enables
bl_en  out  COLS  bit-line switch enables
sl_en  out  COLS  source-line switch enables
wl_vsel  out  2  WL supply select (V1..V4 = 0..3)
bl_vsel  out  2  BL supply select (V1..V4 = 0..3)
sl_vsel  out  1  SL supply select (V1/V2)
pre_en  out  1  BL precharge to VDD_PRE
adc_col  out  3  column routed to ADC
adc_start  out  1  one-cycle ADC convert request
adc_data  in  ADC_BITS  ADC result
adc_valid  in  1  adc_data valid, single cycle
irq  out  1  level interrupt = STATUS.done & CTRL.ie

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0; FSM goes to IDLE; PULSE=PULSE_DEF; VSEL, CTRL, ROWMASK, STATUS and results are 0. Reset mid-op drops all enables on the next edge.
- Wishbone: a hit is cyc&stb with adr[31:8]==ADDR_BASE[31:8]. ack goes high exactly one cycle after a hit with ack low, for one cycle. No ack outside the window. Unmapped offsets read 0; writes to them are dropped. wbs_dat_o is valid with ack.
- Registers (byte offsets):
  - 0x00 CTRL: op[2:0] (1 FORM, 2 SET, 3 RESET, 4 READ, 5 MAC; others NOP), row[12:8], col[18:16], ie[24], start[31] (self-clearing, reads 0).
  - 0x04 STATUS: busy[0] RO, done[1] W1C, timeout[2] W1C, busy_err[3] W1C.
  - 0x08 PULSE[15:0]: pulse cycles; 0 is treated as 1.
  - 0x0C VSEL: wl[1:0], bl[3:2], sl[4].
  - 0x10 ROWMASK[ROWS-1:0].
  - 0x20+4*c RESULT[c][ADC_BITS-1:0] RO, c<COLS.
- Start while busy: ignored and busy_err set. Start with row>=ROWS or col>=COLS: op not run; done and timeout set in the same cycle.
- FSM states: IDLE, SETUP, PULSE, RELEASE, PRECH, SENSE, CONV, WAITADC, STORE, DONE.
- IDLE->SETUP on a valid start; busy=1 from the next cycle.
- SETUP lasts SETTLE_CYC cycles; vsel outputs are driven from VSEL, all enables stay 0.
- FORM/SET/RESET: PULSE state for PULSE cycles with wl_en[row]=1, bl_en[col]=1, sl_en[col]=1. Then RELEASE (1 cycle, all enables 0), then DONE.
- READ: PRECH for PRE_CYC cycles (pre_en=1, bl_en[col]=1). Then SENSE for SENSE_CYC cycles (pre_en=0, wl_en[row], bl_en[col], sl_en[col]). Then CONV: adc_col=col, adc_start=1 for one cycle. Then WAITADC.
- MAC: same flow as READ, but wl_en=ROWMASK and the sequence repeats for col=0..COLS-1, with a PRECH per column. ROWMASK=0 still runs and stores ADC output.
- WAITADC: on adc_valid, go to STORE (RESULT[col]<=adc_data, 1 cycle). STORE moves to the next MAC column or to RELEASE->DONE. If ADC_TIMEOUT cycles pass without adc_valid: set timeout, go to RELEASE->DONE, leave RESULT unchanged.
- DONE (1 cycle): done=1, busy=0 on the next cycle, return to IDLE. adc_valid outside WAITADC is ignored.
- Enables change only at state boundaries. Select outputs never change while any enable is 1.
- Counters are 16 bits; total latency is deterministic given adc_valid timing.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random inputs -> all outputs 0, read PULSE=16, STATUS=0.
- SET: VSEL=0x05, PULSE=3, CTRL op=2 row=1 col=0 start -> 8 setup cycles with wl_vsel=1 and bl_vsel=1; then wl_en=2'b10, bl_en=2'b01, sl_en=2'b01 for exactly 3 cycles; done=1; irq=1 if ie set.
- READ: op=4 row=0 col=1; ADC returns 4'hA three cycles after adc_start -> pre_en high 4 cycles, one adc_start pulse, RESULT[1]=0xA.
- MAC: ROWMASK=2'b11, ADC returns 3 then 7 -> two PRECH/SENSE/CONV passes, adc_col 0 then 1, RESULT[0]=3, RESULT[1]=7.
- ADC timeout: no adc_valid -> timeout=1 after 64 wait cycles, enables 0, RESULT unchanged; W1C clears it.
- Errors: start during busy -> busy_err=1, op unaffected. col=2 with COLS=2 -> immediate done+timeout. Access at 0x3000_0100 -> no ack.
